// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order store buffer for the memory stage. Byte and word stores are queued
// in a circular FIFO and drained oldest-first to the data cache through a
// req/ack handshake. Loads probe the queued stores and either receive
// forwarded data (youngest matching store wins) or a conflict flag when a word
// load only partially overlaps queued byte stores.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   st_*_i / st_ready_o   store push side (st_ready_o = !full)
//   ld_*_i / ld_*_o       combinational load lookup and forwarding
//   mem_*_o / mem_ack_i   drain handshake; mem_* come from the head entry
//   count_o, full_o,      occupancy status
//   empty_o
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     st_valid_i,
    input  logic                     st_byteword_i,
    input  logic [ADDR_W-1:0]        st_addr_i,
    input  logic [DATA_W-1:0]        st_data_i,
    output logic                     st_ready_o,

    input  logic                     ld_valid_i,
    input  logic                     ld_byteword_i,
    input  logic [ADDR_W-1:0]        ld_addr_i,
    output logic                     ld_hit_o,
    output logic                     ld_conflict_o,
    output logic [DATA_W-1:0]        ld_data_o,

    output logic                     mem_req_o,
    output logic                     mem_byteword_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic                     mem_ack_i,

    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage
    logic              bw_q   [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full, empty;
    logic              push, pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A push while full is dropped; an ack while empty is ignored.
    assign push = st_valid_i && !full;
    assign pop  = mem_ack_i && !empty;

    // Word stores are kept word-aligned, byte stores keep only their low byte,
    // so the lookup below can compare addresses and data without masking.
    always_comb begin
        push_addr = st_addr_i;
        push_data = st_data_i;
        if (st_byteword_i) begin
            push_addr[1:0] = 2'b00;
        end else begin
            push_data = {{(DATA_W-8){1'b0}}, st_data_i[7:0]};
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bw_q[i]   <= 1'b0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                bw_q[tail_q]   <= st_byteword_i;
                addr_q[tail_q] <= push_addr;
                data_q[tail_q] <= push_data;
            end
        end
    end

    // Drain side: purely register-driven (head pointer, count, entry regs),
    // forced to zero while empty so stale entries never show on the bus.
    assign mem_req_o      = !empty;
    assign mem_byteword_o = empty ? 1'b0 : bw_q[head_q];
    assign mem_addr_o     = empty ? '0   : addr_q[head_q];
    assign mem_wdata_o    = empty ? '0   : data_q[head_q];

    assign count_o    = count_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign st_ready_o = !full;

    // Load lookup. Entries are visited oldest to youngest (offset k from the
    // head), so a later match simply overwrites an earlier one and the
    // youngest match wins. Only occupied slots (k < count) are considered.
    logic             hit, conflict;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0] idx;
    logic [7:0]       sel_byte;

    always_comb begin
        hit      = 1'b0;
        conflict = 1'b0;
        fwd_data = '0;
        idx      = '0;
        sel_byte = '0;
        if (ld_valid_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_q + PTR_W'(k);
                if (CNT_W'(k) < count_q) begin
                    if (!ld_byteword_i) begin
                        if (!bw_q[idx] && (addr_q[idx] == ld_addr_i)) begin
                            hit      = 1'b1;
                            fwd_data = {{(DATA_W-8){1'b0}}, data_q[idx][7:0]};
                        end else if (bw_q[idx] &&
                                     (addr_q[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])) begin
                            case (ld_addr_i[1:0])
                                2'd0:    sel_byte = data_q[idx][7:0];
                                2'd1:    sel_byte = data_q[idx][15:8];
                                2'd2:    sel_byte = data_q[idx][23:16];
                                default: sel_byte = data_q[idx][31:24];
                            endcase
                            hit      = 1'b1;
                            fwd_data = {{(DATA_W-8){1'b0}}, sel_byte};
                        end
                    end else if (addr_q[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]) begin
                        if (bw_q[idx]) begin
                            hit      = 1'b1;
                            fwd_data = data_q[idx];
                        end else begin
                            conflict = 1'b1;
                        end
                    end
                end
            end
            // Any byte store inside the word makes a word load unforwardable.
            if (conflict) begin
                hit      = 1'b0;
                fwd_data = '0;
            end
        end
    end

    assign ld_hit_o      = hit;
    assign ld_conflict_o = conflict;
    assign ld_data_o     = fwd_data;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk_i;
    logic        reset_i;
    logic        st_valid_i;
    logic        st_byteword_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic        st_ready_o;
    logic        ld_valid_i;
    logic        ld_byteword_i;
    logic [31:0] ld_addr_i;
    logic        ld_hit_o;
    logic        ld_conflict_o;
    logic [31:0] ld_data_o;
    logic        mem_req_o;
    logic        mem_byteword_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .st_valid_i    (st_valid_i),
        .st_byteword_i (st_byteword_i),
        .st_addr_i     (st_addr_i),
        .st_data_i     (st_data_i),
        .st_ready_o    (st_ready_o),
        .ld_valid_i    (ld_valid_i),
        .ld_byteword_i (ld_byteword_i),
        .ld_addr_i     (ld_addr_i),
        .ld_hit_o      (ld_hit_o),
        .ld_conflict_o (ld_conflict_o),
        .ld_data_o     (ld_data_o),
        .mem_req_o     (mem_req_o),
        .mem_byteword_o(mem_byteword_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .count_o       (count_o),
        .full_o        (full_o),
        .empty_o       (empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic store(input logic bw, input logic [31:0] a, input logic [31:0] d);
        st_valid_i    = 1'b1;
        st_byteword_i = bw;
        st_addr_i     = a;
        st_data_i     = d;
        tick();
        st_valid_i    = 1'b0;
    endtask

    task automatic load(input logic bw, input logic [31:0] a);
        ld_valid_i    = 1'b1;
        ld_byteword_i = bw;
        ld_addr_i     = a;
        #1;
    endtask

    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];
    logic        exp_bw   [4];

    initial begin
        reset_i = 1'b1;
        st_valid_i = 1'b0; st_byteword_i = 1'b0; st_addr_i = '0; st_data_i = '0;
        ld_valid_i = 1'b0; ld_byteword_i = 1'b0; ld_addr_i = '0;
        mem_ack_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        #1;

        // Reset state
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_st_ready", 32'(st_ready_o), 32'd1);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_bw", 32'(mem_byteword_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_ld_hit", 32'(ld_hit_o), 32'd0);
        chk("rst_ld_conflict", 32'(ld_conflict_o), 32'd0);
        chk("rst_ld_data", ld_data_o, 32'd0);

        // Single word store and drain
        store(1'b1, 32'h100, 32'hDEADBEEF);
        chk("t1_mem_req", 32'(mem_req_o), 32'd1);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        chk("t1_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("t1_mem_bw", 32'(mem_byteword_o), 32'd1);
        chk("t1_count", 32'(count_o), 32'd1);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        #1;
        chk("t1_empty", 32'(empty_o), 32'd1);
        chk("t1_mem_req_off", 32'(mem_req_o), 32'd0);

        // Fill to full (head now at slot 1, so draining wraps), drop a 5th
        exp_bw[0] = 1'b1; exp_addr[0] = 32'h10; exp_data[0] = 32'hA1A1A1A1;
        exp_bw[1] = 1'b0; exp_addr[1] = 32'h21; exp_data[1] = 32'h00000034;
        exp_bw[2] = 1'b1; exp_addr[2] = 32'h30; exp_data[2] = 32'hC3C3C3C3;
        exp_bw[3] = 1'b1; exp_addr[3] = 32'h40; exp_data[3] = 32'hD4D4D4D4;
        store(1'b1, 32'h10, 32'hA1A1A1A1);
        store(1'b0, 32'h21, 32'hFFFF1234);
        store(1'b1, 32'h33, 32'hC3C3C3C3);
        store(1'b1, 32'h40, 32'hD4D4D4D4);
        chk("t2_full", 32'(full_o), 32'd1);
        chk("t2_st_ready", 32'(st_ready_o), 32'd0);
        chk("t2_count_full", 32'(count_o), 32'd4);
        store(1'b1, 32'h50, 32'hEEEEEEEE);
        chk("t2_count_drop", 32'(count_o), 32'd4);
        // mem_* must hold while unacknowledged
        chk("t2_hold_addr", mem_addr_o, 32'h10);
        mem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_count_%0d", i), 32'(count_o), 32'(4 - i));
            chk($sformatf("t2_addr_%0d", i), mem_addr_o, exp_addr[i]);
            chk($sformatf("t2_data_%0d", i), mem_wdata_o, exp_data[i]);
            chk($sformatf("t2_bw_%0d", i), 32'(mem_byteword_o), 32'(exp_bw[i]));
            tick();
        end
        mem_ack_i = 1'b0;
        #1;
        chk("t2_count_end", 32'(count_o), 32'd0);
        chk("t2_empty_end", 32'(empty_o), 32'd1);

        // Forwarding: word then younger byte
        store(1'b1, 32'h200, 32'h11223344);
        load(1'b0, 32'h202);
        chk("t3_hit", 32'(ld_hit_o), 32'd1);
        chk("t3_data", ld_data_o, 32'h00000022);
        chk("t3_conflict", 32'(ld_conflict_o), 32'd0);
        st_valid_i = 1'b1; st_byteword_i = 1'b0; st_addr_i = 32'h202; st_data_i = 32'h000000AB;
        #1;
        // same-cycle push is not yet visible
        chk("t3_same_cycle", ld_data_o, 32'h00000022);
        tick();
        st_valid_i = 1'b0;
        #1;
        chk("t3_young_data", ld_data_o, 32'h000000AB);
        chk("t3_young_hit", 32'(ld_hit_o), 32'd1);
        load(1'b1, 32'h200);
        chk("t3_wconf", 32'(ld_conflict_o), 32'd1);
        chk("t3_wconf_hit", 32'(ld_hit_o), 32'd0);
        chk("t3_wconf_data", ld_data_o, 32'd0);
        load(1'b1, 32'h204);
        mem_ack_i = 1'b1;
        tick();
        tick();
        mem_ack_i = 1'b0;
        #1;
        chk("t3_drained", 32'(empty_o), 32'd1);

        // Conflict and miss
        store(1'b0, 32'h301, 32'h00000055);
        load(1'b1, 32'h300);
        chk("t4_conflict", 32'(ld_conflict_o), 32'd1);
        chk("t4_conflict_hit", 32'(ld_hit_o), 32'd0);
        load(1'b1, 32'h304);
        chk("t4_miss_hit", 32'(ld_hit_o), 32'd0);
        chk("t4_miss_conflict", 32'(ld_conflict_o), 32'd0);
        load(1'b0, 32'h301);
        chk("t4_byte_hit", 32'(ld_hit_o), 32'd1);
        chk("t4_byte_data", ld_data_o, 32'h00000055);
        ld_valid_i = 1'b0;
        #1;
        chk("t4_novalid_hit", 32'(ld_hit_o), 32'd0);
        chk("t4_novalid_data", ld_data_o, 32'd0);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;

        // Simultaneous push and pop
        store(1'b1, 32'h400, 32'h00000400);
        store(1'b1, 32'h404, 32'h00000404);
        store(1'b1, 32'h408, 32'h00000408);
        store(1'b1, 32'h40C, 32'h0000040C);
        chk("t5_full", 32'(full_o), 32'd1);
        mem_ack_i = 1'b1;
        store(1'b1, 32'h500, 32'h00000500);
        #1;
        chk("t5_full_pp_count", 32'(count_o), 32'd3);
        chk("t5_full_pp_head", mem_addr_o, 32'h404);
        mem_ack_i = 1'b1;
        store(1'b1, 32'h600, 32'h00000600);
        mem_ack_i = 1'b0;
        #1;
        chk("t5_pp_count", 32'(count_o), 32'd3);
        chk("t5_pp_head", mem_addr_o, 32'h408);
        mem_ack_i = 1'b1;
        chk("t5_d0", mem_addr_o, 32'h408);
        tick();
        chk("t5_d1", mem_addr_o, 32'h40C);
        tick();
        chk("t5_d2", mem_addr_o, 32'h600);
        chk("t5_d2_data", mem_wdata_o, 32'h00000600);
        tick();
        mem_ack_i = 1'b0;
        #1;
        chk("t5_empty", 32'(empty_o), 32'd1);

        // Reset during pending drain
        store(1'b1, 32'h700, 32'h77777777);
        store(1'b1, 32'h704, 32'h88888888);
        store(1'b1, 32'h708, 32'h99999999);
        chk("t6_count_pre", 32'(count_o), 32'd3);
        chk("t6_req_pre", 32'(mem_req_o), 32'd1);
        reset_i   = 1'b1;
        mem_ack_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        chk("t6_count", 32'(count_o), 32'd0);
        chk("t6_req", 32'(mem_req_o), 32'd0);
        chk("t6_empty", 32'(empty_o), 32'd1);
        load(1'b1, 32'h700);
        chk("t6_ld_hit", 32'(ld_hit_o), 32'd0);
        tick();
        chk("t6_req_ack_hold", 32'(mem_req_o), 32'd0);
        mem_ack_i  = 1'b0;
        ld_valid_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

In-order store buffer in the memory (M) stage. Accepts byte/word stores qualified by the M-stage `memwrite` and `byteword` controls, holds up to DEPTH of them, and drains them oldest-first to the data cache over a req/ack handshake. Loads in M look up the buffer and receive forwarded data, or a conflict flag that makes the hazard logic stall the load.

## Interface
- DEPTH, 4: entry count; power of two, at least 2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; fixed at 32 (word = 4 bytes).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- st_valid  in  1  store request; M-stage `memwrite`.
- st_byteword  in  1  0 = byte store, 1 = word store.
- st_addr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data; a byte store uses [7:0].
- st_ready  out  1  entry free this cycle (= !full).
- ld_valid  in  1  load lookup request.
- ld_byteword  in  1  0 = byte load, 1 = word load.
- ld_addr  in  ADDR_W  load address.
- ld_hit  out  1  combinational; forwarded data valid.
- ld_conflict  out  1  combinational; partial overlap, load must stall.
- ld_data  out  DATA_W  forwarded data; byte hits are zero-extended.
- mem_req  out  1  drain request to the cache.
- mem_byteword  out  1  width of the head entry.
- mem_addr  out  ADDR_W  address of the head entry.
- mem_wdata  out  DATA_W  data of the head entry.
- mem_ack  in  1  cache accepted the head entry.
- count  out  $clog2(DEPTH)+1  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage is a circular FIFO with head and tail pointers and a per-entry {byteword, addr, data}. Pointers wrap modulo DEPTH.
- Push: st_valid && st_ready writes the entry at tail, and tail advances. A store with st_valid while full is dropped. Upstream must stall on !st_ready.
- Word store: addr[1:0] is ignored; the entry is stored word-aligned.
- Byte store: data[31:8] is stored as 0.
- Drain: mem_req = !empty. mem_* reflect the head entry and stay stable while mem_req is high and mem_ack is low. mem_req && mem_ack pops the head. mem_ack while empty is ignored.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Forwarding only considers entries already in the buffer. A store pushed in the same cycle is not visible to a load until the next cycle.
- A byte load at address A:
  - matches a byte entry whose address equals A;
  - matches a word entry whose address equals A[ADDR_W-1:2],00.
  - The youngest match wins. ld_data is that byte, zero-extended.
  - For a word entry, the byte is selected by A[1:0], little-endian: byte 0 is [7:0].
- A word load at address A:
  - If any byte entry lies in the same word, ld_conflict = 1 and ld_hit = 0.
  - Otherwise, if a word entry matches, ld_hit = 1 and ld_data is the youngest matching entry's data.
- With no match, or with ld_valid = 0: ld_hit = 0, ld_conflict = 0, ld_data = 0.
- ld_hit and ld_conflict are never both 1.

## Timing
- Reset values: head = tail = 0, count = 0, empty = 1, full = 0, st_ready = 1, mem_req = 0, mem_byteword = 0, mem_addr = 0, mem_wdata = 0, ld_* = 0.
- Reset during a pending drain discards every entry. mem_req is 0 from the cycle after reset is sampled, regardless of mem_ack.
- A store pushed at edge N appears on mem_* with mem_req = 1 in cycle N+1 if the buffer was empty.
- count, full, empty and st_ready update on the edge after a push or pop.
- mem_* outputs are driven directly from the head entry's registers, not from combinational paths of any input.
- Back-to-back drain: with mem_ack held high, one entry is retired per cycle.

## Test plan
- Reset, then push word 0x100 ← 0xDEADBEEF. Next cycle: mem_req = 1, mem_addr = 0x100, mem_wdata = 0xDEADBEEF, mem_byteword = 1. Ack for one cycle → empty = 1, mem_req = 0.
- Push 4 stores with mem_ack = 0 → full = 1, st_ready = 0. A 5th store is dropped. Ack 4 cycles → the 4 entries drain in push order with pointer wrap; count goes 4, 3, 2, 1, 0.
- Word 0x200 ← 0x11223344, then a byte load at 0x202 → ld_hit = 1, ld_data = 0x00000022. Then byte 0x202 ← 0xAB and reload → ld_data = 0x000000AB (youngest wins).
- Byte store 0x301 ← 0x55, then a word load at 0x300 → ld_conflict = 1, ld_hit = 0. Word load at 0x304 → ld_hit = 0, ld_conflict = 0.
- Full buffer, then push and ack in the same cycle → push rejected and head popped; count = 3. Non-full buffer, then push and ack in the same cycle → count unchanged.
- 3 entries pending with mem_req = 1, assert reset for one cycle → next cycle count = 0, mem_req = 0, and a load to a previously buffered address gives ld_hit = 0.
